hac_and2: RTL and testbench
===========================

// Module: hac_and2
// PURPOSE
// - Clocked 2-input AND gate cell for the HAC co-simulation gate library.
// - Models one production-rule AND (z = a & b) with a programmable gate
//   delay, and reports output transitions (rise/fall pulses, event count).
// - Instantiated per gate in tree netlists, e.g. and_2(j, k, z) fed by
//   and_0(a, b, j) and and_1(c, d, k); z of one cell drives a/b of the next.
// PARAMETERS
// - PRSIM_NAME  "hac_and2"  instance label used in trace messages only
// - DELAY       1           gate delay in clock cycles, legal 1..8
// - CNT_W       16          width of transition counter
// - WATCH       0           1 = print trace line per z transition (sim only)
// PORTS
// - clk       in   1      clock, all state updates on rising edge
// - rst       in   1      synchronous reset, active-high
// - a         in   1      AND input 0
// - b         in   1      AND input 1
// - z         out  1      gate output, a & b delayed DELAY cycles
// - z_rise    out  1      1-cycle pulse, z went 0->1 this cycle
// - z_fall    out  1      1-cycle pulse, z went 1->0 this cycle
// - n_events  out  CNT_W  count of z transitions since reset, saturating
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - Reset (rst=1 at clk edge): z=0, z_rise=0, z_fall=0, n_events=0,
//   all DELAY pipeline stages cleared to 0. Reset mid-operation discards
//   in-flight values; no pulse or count on the reset-induced z change.
// - Evaluation: each edge, f = a & b is sampled into stage 0 of a
//   DELAY-deep transport shift register; z = last stage. Input change
//   at sample edge t appears on z at edge t+DELAY-1 (DELAY=1: z updates
//   on the same edge that samples a/b).
// - Transport, not inertial: a 1-cycle input glitch produces a 1-cycle
//   z pulse after DELAY; no filtering.
// - Three-valued inputs (sim): a=0 or b=0 forces f=0 even if other is X;
//   both 1 -> f=1; otherwise f=X (standard Verilog & semantics).
// - z_rise/z_fall: registered alongside z; asserted the cycle z holds its
//   new value; never both high; X->0/1 or 0/1->X is not a transition.
// - n_events: +1 per z_rise or z_fall; holds at 2^CNT_W-1.
// - WATCH=1: on each transition $display "<PRSIM_NAME>.z : <0|1>" with
//   %t time; excluded from synthesis (translate_off).
// - DELAY outside 1..8: elaboration-time $error.
// TESTING
// - Reset: rst=1 two cycles, a=b=1 -> z=0, pulses 0, n_events=0.
// - Truth table, DELAY=1: a,b = 00,01,10,11 -> z = 0,0,0,1; one
//   z_rise at 11, n_events=1.
// - Sequence a=b=1 then a=0, then a=1 -> z 1->0->1, z_fall then z_rise
//   each 1 cycle wide, n_events=3 after initial rise.
// - DELAY=4: a=b step 0->1 at edge t -> z=1 first at edge t+3; 1-cycle
//   glitch on b -> 1-cycle z low pulse 3 cycles later.
// - Tree of 3 cells (DELAY=1): a=b=c=d 0->1 -> z=1 one cycle after j,k;
//   d=0 -> k=0 then z=0; d=1 -> z back to 1.
// - Saturation with CNT_W=2: toggle a 5 times, b=1 -> n_events stops at 3;
//   rst mid-pipeline (DELAY=4) -> z=0, no pulse, count 0.

Source files
------------

// File: rtl/hac_and2_if.sv
// Signal bundle for one hac_and2 gate cell: the two AND inputs plus the
// output, its transition pulses and the transition counter.
interface hac_and2_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             a;
  logic             b;
  logic             z;
  logic             z_rise;
  logic             z_fall;
  logic [CNT_W-1:0] n_events;

  // master drives the gate inputs; slave is the gate cell itself
  modport master (
    output a,
    output b,
    input  z,
    input  z_rise,
    input  z_fall,
    input  n_events
  );

  modport slave (
    input  a,
    input  b,
    output z,
    output z_rise,
    output z_fall,
    output n_events
  );

endinterface

// File: rtl/hac_and2.sv
// Clocked 2-input AND gate with a DELAY-deep transport pipeline, registered
// rise/fall pulses on the output and a saturating transition counter.
module hac_and2 #(
  parameter string       PRSIM_NAME = "hac_and2",
  parameter int unsigned DELAY      = 1,
  parameter int unsigned CNT_W      = 16,
  parameter bit          WATCH      = 1'b0
) (
  input logic       clk,
  input logic       rst,
  hac_and2_if.slave bus
);

  if (DELAY < 1 || DELAY > 8) begin : g_bad_delay
    $error("hac_and2 %s: DELAY=%0d outside legal range 1..8", PRSIM_NAME, DELAY);
  end

  // Clamp so an illegal DELAY still elaborates far enough to report the error
  localparam int unsigned Depth = (DELAY < 1) ? 1 : ((DELAY > 8) ? 8 : DELAY);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             f;
  logic [Depth-1:0] stage_q, stage_d;
  logic             z_next;
  logic             rise_d, rise_q;
  logic             fall_d, fall_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    f          = bus.a & bus.b;
    stage_d    = stage_q;
    stage_d[0] = f;
    for (int i = 1; i < Depth; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    z_next = stage_d[Depth-1];
    // Case equality keeps X->0/1 and 0/1->X from counting as transitions
    rise_d = (z_next === 1'b1) && (stage_q[Depth-1] === 1'b0);
    fall_d = (z_next === 1'b0) && (stage_q[Depth-1] === 1'b1);
    cnt_d  = cnt_q;
    if ((rise_d || fall_d) && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.z        = stage_q[Depth-1];
  assign bus.z_rise   = rise_q;
  assign bus.z_fall   = fall_q;
  assign bus.n_events = cnt_q;

`ifndef SYNTHESIS
  if (WATCH) begin : g_watch
    always @(posedge clk) begin
      if (!rst && (rise_d || fall_d)) begin
        $display("%t %s.z : %0b", $time, PRSIM_NAME, z_next);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hac_and2.sv
// Scoreboard bench: a DELAY=1 cell, a DELAY=4 cell with a 2-bit counter, and a
// three-cell AND tree, all checked against a history-queue reference model.
module tb_hac_and2;

  logic clk = 1'b0;
  logic rst;
  logic a, b, c, d;

  always #5 clk = ~clk;

  hac_and2_if #(.CNT_W(16)) bus1 ();
  hac_and2_if #(.CNT_W(2))  bus4 ();
  hac_and2_if #(.CNT_W(16)) t0 ();
  hac_and2_if #(.CNT_W(16)) t1 ();
  hac_and2_if #(.CNT_W(16)) t2 ();

  assign bus1.a = a;
  assign bus1.b = b;
  assign bus4.a = a;
  assign bus4.b = b;
  assign t0.a   = a;
  assign t0.b   = b;
  assign t1.a   = c;
  assign t1.b   = d;
  assign t2.a   = t0.z;
  assign t2.b   = t1.z;

  hac_and2 #(.PRSIM_NAME("and_d1"), .DELAY(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  hac_and2 #(.PRSIM_NAME("and_d4"), .DELAY(4), .CNT_W(2)) u_d4 (
    .clk(clk), .rst(rst), .bus(bus4.slave));
  hac_and2 #(.PRSIM_NAME("and_0"), .DELAY(1), .CNT_W(16)) and_0 (
    .clk(clk), .rst(rst), .bus(t0.slave));
  hac_and2 #(.PRSIM_NAME("and_1"), .DELAY(1), .CNT_W(16)) and_1 (
    .clk(clk), .rst(rst), .bus(t1.slave));
  hac_and2 #(.PRSIM_NAME("and_2"), .DELAY(1), .CNT_W(16)) and_2 (
    .clk(clk), .rst(rst), .bus(t2.slave));

  typedef struct packed {
    logic        z;
    logic        rise;
    logic        fall;
    logic [15:0] cnt;
  } exp_t;

  // Channel 0: DELAY=1 cell, 1: DELAY=4 cell, 2: tree output (two gate delays)
  exp_t        exp_q [3][$];
  bit          hist  [3][$];
  bit          zprev [3];
  int unsigned cnt   [3];
  int unsigned dly   [3] = '{1, 4, 2};
  int unsigned cmax  [3] = '{65535, 3, 65535};
  string       nm    [3] = '{"d1", "d4", "tree"};

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: output equals the AND value sampled dly-1 edges ago, or 0 while
  // fewer than dly samples have been taken since reset.
  task automatic model_edge();
    bit   f [3];
    exp_t e;
    bit   zv;
    f[0] = a & b;
    f[1] = a & b;
    f[2] = a & b & c & d;
    for (int ch = 0; ch < 3; ch++) begin
      if (rst) begin
        hist[ch].delete();
        zprev[ch] = 1'b0;
        cnt[ch]   = 0;
        e         = '0;
      end else begin
        hist[ch].push_back(f[ch]);
        if (hist[ch].size() > dly[ch]) void'(hist[ch].pop_front());
        zv     = (hist[ch].size() == dly[ch]) ? hist[ch][0] : 1'b0;
        e.z    = zv;
        e.rise = zv && !zprev[ch];
        e.fall = !zv && zprev[ch];
        if ((e.rise || e.fall) && cnt[ch] < cmax[ch]) cnt[ch]++;
        e.cnt     = 16'(cnt[ch]);
        zprev[ch] = zv;
      end
      exp_q[ch].push_back(e);
    end
  endtask

  task automatic apply(input bit r, input bit va, input bit vb, input bit vc, input bit vd);
    rst = r;
    a   = va;
    b   = vb;
    c   = vc;
    d   = vd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Monitor: every cycle the cells present outputs; compare against the queue
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      for (int ch = 0; ch < 3; ch++) begin
        if (exp_q[ch].size() > 0) begin
          e = exp_q[ch].pop_front();
          case (ch)
            0:       act = {bus1.z, bus1.z_rise, bus1.z_fall, bus1.n_events};
            1:       act = {bus4.z, bus4.z_rise, bus4.z_fall, 14'd0, bus4.n_events};
            default: act = {t2.z, t2.z_rise, t2.z_fall, t2.n_events};
          endcase
          n_cmp++;
          if (act !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got z=%b rise=%b fall=%b n=%0d, want z=%b rise=%b fall=%b n=%0d",
                     nm[ch], $time, act.z, act.rise, act.fall, act.cnt,
                     e.z, e.rise, e.fall, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    a = 1'b1; b = 1'b1; c = 1'b1; d = 1'b1;
    // Reset held two cycles with a=b=1
    apply(1, 1, 1, 1, 1);
    apply(1, 1, 1, 1, 1);
    // Truth table, then fall and rise again
    apply(0, 0, 0, 1, 1);
    apply(0, 0, 1, 1, 1);
    apply(0, 1, 0, 1, 1);
    apply(0, 1, 1, 1, 1);
    apply(0, 0, 1, 1, 1);
    apply(0, 1, 1, 1, 1);
    for (int i = 0; i < 5; i++) apply(0, 1, 1, 1, 1);
    // One-cycle glitch on b, then tree d low/high
    apply(0, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) apply(0, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) apply(0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) apply(0, 1, 1, 1, 1);
    // Toggle a to drive the 2-bit counter into saturation
    for (int i = 0; i < 10; i++) apply(0, i[0], 1, 1, 1);
    for (int i = 0; i < 4; i++) apply(0, 1, 1, 1, 1);
    // Reset with values still in the DELAY=4 pipeline
    apply(0, 0, 1, 1, 1);
    apply(0, 1, 1, 1, 1);
    apply(1, 1, 1, 1, 1);
    for (int i = 0; i < 6; i++) apply(0, 1, 1, 1, 1);
    // Randomized traffic, inputs biased high so the AND output toggles often
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #2;
    for (int ch = 0; ch < 3; ch++) begin
      if (exp_q[ch].size() != 0) begin
        n_fail++;
        $display("FAIL %s drain: got %0d pending, want 0", nm[ch], exp_q[ch].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
